// File: rtl/prbs_ber_checker.sv
// PRBS bit-error-rate checker: self-synchronises to a PRBS stream and counts bits/errors while locked.
// Optional snapshot registers are enabled by defining PRBS_BER_SNAPSHOT_EN.
module prbs_ber_checker #(
  parameter int ORDER    = 7,
  parameter int TAP      = 6,
  parameter int LOCK_CNT = 32,
  parameter int WINDOW   = 1024,
  parameter int LOSS_TH  = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
`ifdef PRBS_BER_SNAPSHOT_EN
  input  logic             snap,
  output logic [CNT_W-1:0] snap_bits,
  output logic [CNT_W-1:0] snap_errs,
`endif
  output logic             locked,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse
);

  localparam int FILL_W  = $clog2(ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(WINDOW + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(ORDER - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  LOSS_LIM   = WERR_W'(LOSS_TH);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t             state, state_n;
  logic [ORDER-1:0]   lfsr, lfsr_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [MATCH_W-1:0] match, match_n;
  logic [WIN_W-1:0]   wbits, wbits_n;
  logic [WERR_W-1:0]  werrs, werrs_n, werr_now;
  logic [CNT_W-1:0]   bit_n, err_n;
  logic               pulse_n, pred, miss, sat;
  logic [ORDER-1:0]   shift_din;

  assign pred      = lfsr[ORDER-1] ^ lfsr[TAP-1];
  assign shift_din = {lfsr[ORDER-2:0], din};
  assign sat       = &bit_count;
  assign locked    = (state == LOCKED);

  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    fill_n   = fill;
    match_n  = match;
    wbits_n  = wbits;
    werrs_n  = werrs;
    bit_n    = bit_count;
    err_n    = err_count;
    pulse_n  = 1'b0;
    miss     = (din != pred);
    werr_now = werrs + {{(WERR_W-1){1'b0}}, miss};
    if (din_valid) begin
      case (state)
        HUNT: begin
          lfsr_n = shift_din;
          if (fill == FILL_LAST) begin
            // an all-zero seed would predict zeros forever, so refill instead
            fill_n = '0;
            if (shift_din != '0) state_n = VERIFY;
          end else begin
            fill_n = fill + FILL_W'(1);
          end
        end
        VERIFY: begin
          lfsr_n = shift_din;
          if (!miss) begin
            if (match == MATCH_LAST) begin
              state_n = LOCKED;
              match_n = '0;
              wbits_n = '0;
              werrs_n = '0;
            end else begin
              match_n = match + MATCH_W'(1);
            end
          end else begin
            state_n = HUNT;
            fill_n  = '0;
            match_n = '0;
          end
        end
        LOCKED: begin
          // flywheel: the predicted bit is fed back so line errors never corrupt the LFSR
          lfsr_n  = {lfsr[ORDER-2:0], pred};
          pulse_n = miss;
          if (!sat) begin
            bit_n = bit_count + CNT_W'(1);
            if (miss) err_n = err_count + CNT_W'(1);
          end
          if (wbits == WIN_LAST) begin
            wbits_n = '0;
            werrs_n = '0;
            if (werr_now > LOSS_LIM) begin
              state_n = HUNT;
              fill_n  = '0;
            end
          end else begin
            wbits_n = wbits + WIN_W'(1);
            werrs_n = werr_now;
          end
        end
        default: state_n = HUNT;
      endcase
    end
    if (clear) begin
      bit_n = '0;
      err_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      lfsr      <= '0;
      fill      <= '0;
      match     <= '0;
      wbits     <= '0;
      werrs     <= '0;
      bit_count <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      fill      <= fill_n;
      match     <= match_n;
      wbits     <= wbits_n;
      werrs     <= werrs_n;
      bit_count <= bit_n;
      err_count <= err_n;
      err_pulse <= pulse_n;
    end
  end

`ifdef PRBS_BER_SNAPSHOT_EN
  // latches the registered (pre-clear) counter values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_bits <= '0;
      snap_errs <= '0;
    end else if (snap) begin
      snap_bits <= bit_count;
      snap_errs <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed self-checking bench for prbs_ber_checker (PRBS7 x^7+x^6+1 stimulus, seed 7'h7F).
module tb_prbs_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic        err_pulse;
`ifdef PRBS_BER_SNAPSHOT_EN
  logic [31:0] snap_bits;
  logic [31:0] snap_errs;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [6:0]  tx;
  int unsigned exp_err;

  // locked bits seen before the random-data phase: 1000 + 1000 + 200 + 2
  localparam int unsigned LOCKED_SO_FAR = 2202;
  localparam int unsigned TO_WIN_END    = 1024 - (LOCKED_SO_FAR % 1024);

  prbs_ber_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
`ifdef PRBS_BER_SNAPSHOT_EN
    .snap      (1'b0),
    .snap_bits (snap_bits),
    .snap_errs (snap_errs),
`endif
    .locked    (locked),
    .bit_count (bit_count),
    .err_count (err_count),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input logic b, input logic v, input logic c);
    din = b;
    din_valid = v;
    clear = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic next_prbs(output logic b);
    b  = tx[6] ^ tx[5];
    tx = {tx[5:0], b};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0d expected 0", locked); else passed++;
    total++; if (bit_count !== 32'd0) $display("FAIL reset_bits: got %0d expected 0", bit_count); else passed++;
    total++; if (err_count !== 32'd0) $display("FAIL reset_errs: got %0d expected 0", err_count); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL reset_pulse: got %0d expected 0", err_pulse); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_lock();
    logic b;
    tx = 7'h7F;
    for (int i = 1; i <= 39; i++) begin
      next_prbs(b);
      step(b, 1'b1, 1'b0);
      if (i == 38) begin
        total++; if (locked !== 1'b0) $display("FAIL lock_early: got %0d expected 0", locked); else passed++;
      end
    end
    total++; if (locked !== 1'b1) $display("FAIL lock_at_39: got %0d expected 1", locked); else passed++;
    total++; if (bit_count !== 32'd0) $display("FAIL lock_bits0: got %0d expected 0", bit_count); else passed++;
    for (int i = 0; i < 1000; i++) begin
      next_prbs(b);
      step(b, 1'b1, 1'b0);
    end
    total++; if (bit_count !== 32'd1000) $display("FAIL lock_bits1000: got %0d expected 1000", bit_count); else passed++;
    total++; if (err_count !== 32'd0) $display("FAIL lock_errs: got %0d expected 0", err_count); else passed++;
  endtask

  task automatic test_errors();
    logic b;
    int unsigned pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      next_prbs(b);
      step((i % 100 == 50) ? ~b : b, 1'b1, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (err_count !== 32'd10) $display("FAIL err_count10: got %0d expected 10", err_count); else passed++;
    total++; if (pulses != 10) $display("FAIL err_pulses10: got %0d expected 10", pulses); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL err_locked: got %0d expected 1", locked); else passed++;
    for (int i = 0; i < 200; i++) begin
      next_prbs(b);
      step(b, 1'b1, 1'b0);
    end
    total++; if (err_count !== 32'd10) $display("FAIL no_slip_errs: got %0d expected 10", err_count); else passed++;
    total++; if (bit_count !== 32'd2200) $display("FAIL no_slip_bits: got %0d expected 2200", bit_count); else passed++;
  endtask

  task automatic test_clear();
    logic b;
    next_prbs(b);
    step(~b, 1'b1, 1'b1);
    total++; if (bit_count !== 32'd0) $display("FAIL clear_bits: got %0d expected 0", bit_count); else passed++;
    total++; if (err_count !== 32'd0) $display("FAIL clear_errs: got %0d expected 0", err_count); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL clear_pulse: got %0d expected 1", err_pulse); else passed++;
    next_prbs(b);
    step(b, 1'b1, 1'b0);
    total++; if (bit_count !== 32'd1) $display("FAIL post_clear_bits: got %0d expected 1", bit_count); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL post_clear_pulse: got %0d expected 0", err_pulse); else passed++;
  endtask

  task automatic test_loss_relock();
    logic b, r;
    int unsigned waited = 0;
    exp_err = 0;
    for (int unsigned i = 1; i <= TO_WIN_END; i++) begin
      r = 1'($urandom_range(0, 1));
      next_prbs(b);
      if (r != b) exp_err++;
      step(r, 1'b1, 1'b0);
      if (i == TO_WIN_END - 1) begin
        total++; if (locked !== 1'b1) $display("FAIL loss_early: got %0d expected 1", locked); else passed++;
      end
    end
    total++; if (locked !== 1'b0) $display("FAIL loss_at_window: got %0d expected 0", locked); else passed++;
    for (int unsigned i = TO_WIN_END; i < 2048; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    total++; if (locked !== 1'b0) $display("FAIL loss_stays: got %0d expected 0", locked); else passed++;
    total++; if (bit_count !== 32'(1 + TO_WIN_END)) $display("FAIL loss_bits_hold: got %0d expected %0d", bit_count, 1 + TO_WIN_END); else passed++;
    total++; if (err_count !== 32'(exp_err)) $display("FAIL loss_errs_hold: got %0d expected %0d", err_count, exp_err); else passed++;
    while (locked !== 1'b1 && waited < 120) begin
      next_prbs(b);
      step(b, 1'b1, 1'b0);
      waited++;
    end
    total++; if (locked !== 1'b1) $display("FAIL relock: got %0d expected 1 after %0d bits", locked, waited); else passed++;
    for (int i = 0; i < 100; i++) begin
      next_prbs(b);
      step(b, 1'b1, 1'b0);
    end
    total++; if (bit_count !== 32'(101 + TO_WIN_END)) $display("FAIL relock_bits: got %0d expected %0d", bit_count, 101 + TO_WIN_END); else passed++;
    total++; if (err_count !== 32'(exp_err)) $display("FAIL relock_errs: got %0d expected %0d", err_count, exp_err); else passed++;
  endtask

  task automatic test_const_zero();
    int unsigned bad = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL zero_locked: got %0d locked cycles expected 0", bad); else passed++;
    total++; if (bit_count !== 32'd0) $display("FAIL zero_bits: got %0d expected 0", bit_count); else passed++;
    total++; if (err_count !== 32'd0) $display("FAIL zero_errs: got %0d expected 0", err_count); else passed++;
  endtask

  task automatic test_gaps();
    logic b;
    int unsigned idle_pulses = 0;
    do_reset();
    tx = 7'h7F;
    for (int i = 1; i <= 39; i++) begin
      next_prbs(b);
      step(b, 1'b1, 1'b0);
      if (i == 38) begin
        total++; if (locked !== 1'b0) $display("FAIL gap_lock_early: got %0d expected 0", locked); else passed++;
      end
      if (i != 39) repeat ((i % 5) + 1) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    total++; if (locked !== 1'b1) $display("FAIL gap_lock_at_39: got %0d expected 1", locked); else passed++;
    for (int i = 0; i < 1000; i++) begin
      repeat ((i % 5) + 1) begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if (err_pulse !== 1'b0) idle_pulses++;
      end
      next_prbs(b);
      step((i == 500 || i == 999) ? ~b : b, 1'b1, 1'b0);
    end
    total++; if (bit_count !== 32'd1000) $display("FAIL gap_bits: got %0d expected 1000", bit_count); else passed++;
    total++; if (err_count !== 32'd2) $display("FAIL gap_errs: got %0d expected 2", err_count); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL gap_last_pulse: got %0d expected 1", err_pulse); else passed++;
    total++; if (idle_pulses != 0) $display("FAIL gap_idle_pulse: got %0d expected 0", idle_pulses); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (locked !== 1'b0) $display("FAIL rst_mid_locked: got %0d expected 0", locked); else passed++;
    total++; if (bit_count !== 32'd0) $display("FAIL rst_mid_bits: got %0d expected 0", bit_count); else passed++;
    total++; if (err_count !== 32'd0) $display("FAIL rst_mid_errs: got %0d expected 0", err_count); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL rst_mid_pulse: got %0d expected 0", err_pulse); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_errors();
    test_clear();
    test_loss_relock();
    test_const_zero();
    test_gaps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
